// File: rtl/bbs_pkg.sv
// Shared definitions for the Blum Blum Shub seed front end.
// Holds the default operand width and the seed validator's sequencing states.
// No logic; imported by seed_val and its interface.
package bbs_pkg;

  localparam int BBS_W = 16;

  // WAIT is the post-reset holding state; DONE is sticky until the next reset.
  typedef enum logic [1:0] {
    WAIT = 2'd0,
    IDLE = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } sv_state_e;

endpackage

// File: rtl/seed_val_if.sv
// Operand/result bundle between the seed source and the seed validator.
// Ports: seed, m (operands, driven by master); gcd_rdy, test_out,
//        result_valid, seed_valid (status/result, driven by slave).
interface seed_val_if #(
  parameter int W = bbs_pkg::BBS_W
);

  logic [W-1:0] seed;
  logic [W-1:0] m;
  logic         gcd_rdy;
  logic [W-1:0] test_out;
  logic         result_valid;
  logic         seed_valid;

  modport master (
    output seed,
    output m,
    input  gcd_rdy,
    input  test_out,
    input  result_valid,
    input  seed_valid
  );

  modport slave (
    input  seed,
    input  m,
    output gcd_rdy,
    output test_out,
    output result_valid,
    output seed_valid
  );

endinterface

// File: rtl/seed_val_gcd_unit.sv
// Iterative subtractive-Euclid GCD engine with val/rdy operand and result ports.
// Latency: one cycle per compare/swap/subtract step after operand capture.
// Backpressure: result is held (result_val high) until result_rdy; operands_rdy low while busy.
// Ports: clk, reset (async active-low); operands_val/operands_rdy, op_a_i, op_b_i;
//        result_val/result_rdy, result_dat.
module gcd_unit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         operands_val,
  output logic         operands_rdy,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  output logic         result_val,
  input  logic         result_rdy,
  output logic [W-1:0] result_dat
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         busy_q, busy_d;

  assign operands_rdy = ~busy_q;
  // B reaching zero means A holds the gcd; presented straight from the registers.
  assign result_val   = busy_q && (b_q == '0);
  assign result_dat   = a_q;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    busy_d = busy_q;
    if (!busy_q) begin
      if (operands_val) begin
        a_d    = op_a_i;
        b_d    = op_b_i;
        busy_d = 1'b1;
      end
    end else if (b_q == '0) begin
      if (result_rdy) begin
        busy_d = 1'b0;
      end
    end else if (a_q < b_q) begin
      a_d = b_q;
      b_d = a_q;
    end else begin
      // a_q >= b_q here, so the subtraction cannot wrap.
      a_d = a_q - b_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/seed_val.sv
// BBS seed validator: computes gcd(m, seed) and flags the seed when it is coprime to m.
// Latency: capture edge plus one cycle per Euclid step (worst case ~2^W cycles).
// Backpressure: one job per reset; result held in DONE until reset is pulsed.
// Ports: clk, reset (async active-low), bus (seed_val_if.slave: seed, m in;
//        gcd_rdy, test_out, result_valid, seed_valid out).
// Optional: define SEED_VAL_RANGE_CHECK_EN to also require 1 < seed < m.
module seed_val
  import bbs_pkg::*;
#(
  parameter int W = BBS_W
) (
  input  logic       clk,
  input  logic       reset,
  seed_val_if.slave  bus
);

  sv_state_e    state_q, state_d;
  logic [W-1:0] test_out_q, test_out_d;
  logic         seed_valid_q, seed_valid_d;

  logic         operands_val;
  logic         operands_rdy;
  logic         result_val;
  logic         result_rdy;
  logic [W-1:0] result_dat;
  logic         coprime;

  gcd_unit #(.W(W)) u_gcd (
    .clk          (clk),
    .reset        (reset),
    .operands_val (operands_val),
    .operands_rdy (operands_rdy),
    .op_a_i       (bus.m),
    .op_b_i       (bus.seed),
    .result_val   (result_val),
    .result_rdy   (result_rdy),
    .result_dat   (result_dat)
  );

`ifdef SEED_VAL_RANGE_CHECK_EN
  logic [W-1:0] seed_q, seed_d;
  logic [W-1:0] m_q, m_d;

  assign coprime = (result_dat == W'(1)) && (seed_q > W'(1)) && (seed_q < m_q);

  always_comb begin
    seed_d = seed_q;
    m_d    = m_q;
    // Snapshot taken on the same edge the gcd engine captures its operands.
    if (state_q == IDLE && operands_rdy) begin
      seed_d = bus.seed;
      m_d    = bus.m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_q <= '0;
      m_q    <= '0;
    end else begin
      seed_q <= seed_d;
      m_q    <= m_d;
    end
  end
`else
  assign coprime = (result_dat == W'(1));
`endif

  always_comb begin
    state_d      = state_q;
    test_out_d   = test_out_q;
    seed_valid_d = seed_valid_q;
    operands_val = 1'b0;
    result_rdy   = 1'b0;
    case (state_q)
      WAIT: state_d = IDLE;
      IDLE: begin
        operands_val = 1'b1;
        if (operands_rdy) state_d = CALC;
      end
      CALC: begin
        result_rdy = 1'b1;
        if (result_val) begin
          state_d      = DONE;
          test_out_d   = result_dat;
          seed_valid_d = coprime;
        end
      end
      DONE: state_d = DONE;
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT;
      test_out_q   <= '0;
      seed_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      test_out_q   <= test_out_d;
      seed_valid_q <= seed_valid_d;
    end
  end

  // Status is decoded from state only; seed_valid_q is only ever set on DONE entry.
  assign bus.gcd_rdy      = (state_q == IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.test_out     = test_out_q;
  assign bus.seed_valid   = seed_valid_q;

endmodule

// File: tb/tb_seed_val.sv
// Self-checking bench for seed_val: scoreboard of expected gcd/valid per job.
// Expected values come from a modulo-Euclid reference model.
module tb_seed_val;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] g;
    logic         v;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  exp_t sb_q[$];

  seed_val_if #(.W(W)) bus ();

  seed_val #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] mm);
    exp_t         e;
    logic [W-1:0] a, b, t;
    a = mm;
    b = s;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    e.g = a;
`ifdef SEED_VAL_RANGE_CHECK_EN
    e.v = (a == 1) && (s > 1) && (s < mm);
`else
    e.v = (a == 1);
`endif
    return e;
  endfunction

  // Assert reset away from the clock edge and confirm the async clear.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_gcd_rdy", 32'(bus.gcd_rdy), 0);
    chk("rst_result_valid", 32'(bus.result_valid), 0);
    chk("rst_seed_valid", 32'(bus.seed_valid), 0);
    chk("rst_test_out", 32'(bus.test_out), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("wait_gcd_rdy", 32'(bus.gcd_rdy), 0);
  endtask

  task automatic start_job(input logic [W-1:0] s, input logic [W-1:0] mm, output bit ok);
    int i;
    ok = 1'b0;
    for (i = 0; i < 8; i++) begin
      if (bus.gcd_rdy) break;
      @(negedge clk);
    end
    if (!bus.gcd_rdy) begin
      chk("gcd_rdy_timeout", 0, 1);
      return;
    end
    bus.seed = s;
    bus.m    = mm;
    sb_q.push_back(model(s, mm));
    @(negedge clk);
    chk("gcd_rdy_one_cycle", 32'(bus.gcd_rdy), 0);
    ok = 1'b1;
  endtask

  task automatic finish_job(input string tag);
    exp_t e;
    bit   saw_rdy;
    int   i;
    saw_rdy = 1'b0;
    for (i = 0; i < 70000; i++) begin
      if (bus.gcd_rdy) saw_rdy = 1'b1;
      if (bus.result_valid) break;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    if (!bus.result_valid) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_rdy_in_calc"}, 32'(saw_rdy), 0);
    chk({tag, "_rdy_with_valid"}, 32'(bus.gcd_rdy), 0);
    chk({tag, "_test_out"}, 32'(bus.test_out), 32'(e.g));
    chk({tag, "_seed_valid"}, 32'(bus.seed_valid), 32'(e.v));
    repeat (3) @(negedge clk);
    chk({tag, "_held"}, {bus.result_valid, bus.seed_valid, 14'd0, bus.test_out},
        {1'b1, e.v, 14'd0, e.g});
  endtask

  task automatic run_job(input string tag, input logic [W-1:0] s, input logic [W-1:0] mm);
    bit ok;
    do_reset();
    start_job(s, mm, ok);
    if (ok) finish_job(tag);
  endtask

  initial begin
    bit ok;
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.seed = '0;
    bus.m    = '0;

    run_job("s3_m253", 16'd3, 16'd253);
    run_job("s3_m6", 16'd3, 16'd6);
    run_job("s0_m7", 16'd0, 16'd7);
    run_job("s0_m0", 16'd0, 16'd0);
    run_job("s7_m0", 16'd7, 16'd0);
    run_job("s18_m12", 16'd18, 16'd12);

    // Abort a job mid-calculation; the reset task checks the async clear.
    do_reset();
    start_job(16'd12, 16'd18, ok);
    if (ok) begin
      @(negedge clk);
      chk("abort_mid_calc", 32'(bus.result_valid), 0);
      void'(sb_q.pop_front());
    end
    do_reset();
    start_job(16'd5, 16'd21, ok);
    if (ok) finish_job("s5_m21");

    run_job("s300_m253", 16'd300, 16'd253);
    run_job("s1_m253", 16'd1, 16'd253);
    run_job("s1_m65535", 16'd1, 16'd65535);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
